comparator_serial_signed_lt: RTL

- Bit-serial, multi-cycle counterpart of the team's flat combinational 32-bit signed less-than comparator.
- Accepts operands a and b in parallel through a valid/ready handshake, then resolves a < b by scanning one bit per cycle, LSB first.
- Returns the result through a valid/ready handshake.
- Used in area-constrained crypto datapaths where a single-cycle comparator cone is too large; also the golden sequential model for equivalence runs against the combinational netlist.

---
 rtl/comparator_pkg.sv | 18 +
 rtl/serial_cmp_cell.sv | 33 +++
 rtl/comparator_serial_signed_lt.sv | 126 ++++++++++++
 3 files changed

// File: rtl/comparator_pkg.sv
// comparator_pkg
// Shared definitions for the bit-serial comparator family:
//   - FSM state encoding (2 bits)
//   - compare-mode constants
//   - default operand width
package comparator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cmp_state_t;

    localparam logic CMP_UNSIGNED      = 1'b0;
    localparam logic CMP_SIGNED        = 1'b1;
    localparam int   CMP_DEFAULT_WIDTH = 32;

endpackage

// File: rtl/serial_cmp_cell.sv
// serial_cmp_cell
// One-bit update step of an LSB-first magnitude compare. Bits are visited
// from low to high, so a differing bit always overrides whatever the lower
// bits decided.
// Ports:
//   a_bit, b_bit   current operand bits
//   is_msb         current bit is the sign position
//   is_signed      1 = two's complement compare
//   lt_in, eq_in   accumulated result from the lower bits
//   lt_out, eq_out updated result
module serial_cmp_cell (
    input  logic a_bit,
    input  logic b_bit,
    input  logic is_msb,
    input  logic is_signed,
    input  logic lt_in,
    input  logic eq_in,
    output logic lt_out,
    output logic eq_out
);

    always_comb begin
        lt_out = lt_in;
        eq_out = eq_in;
        if (a_bit != b_bit) begin
            // At the sign position of a signed compare, the operand with the
            // set bit is the negative one and therefore the smaller one.
            lt_out = (is_msb && is_signed) ? a_bit : b_bit;
            eq_out = 1'b0;
        end
    end

endmodule

// File: rtl/comparator_serial_signed_lt.sv
// comparator_serial_signed_lt
// Bit-serial a < b / a == b comparator, signed or unsigned, one bit per
// cycle LSB first. Operands enter through an in_valid/in_ready handshake and
// the result leaves through an out_valid/out_ready handshake.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid, in_ready    operand handshake (in_ready high only in IDLE)
//   a, b, is_signed       operands and compare mode, captured on accept
//   out_valid, out_ready  result handshake (out_valid high only in DONE)
//   lt, eq                result, held stable while out_valid & ~out_ready
//
// state | meaning
// IDLE  | waiting for operands
// RUN   | scanning one bit per cycle, counter = index of bit being examined
// DONE  | result presented, waiting for out_ready
module comparator_serial_signed_lt
    import comparator_pkg::*;
#(
    parameter int WIDTH = CMP_DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             lt,
    output logic             eq
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    cmp_state_t       state;
    cmp_state_t       state_nxt;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic             mode;
    logic [CNT_W-1:0] counter;
    logic             lt_acc;
    logic             eq_acc;
    logic             lt_upd;
    logic             eq_upd;
    logic             last_bit;

    assign last_bit = (counter == LAST_BIT);

    serial_cmp_cell u_cell (
        .a_bit     (sa[0]),
        .b_bit     (sb[0]),
        .is_msb    (last_bit),
        .is_signed (mode == CMP_SIGNED),
        .lt_in     (lt_acc),
        .eq_in     (eq_acc),
        .lt_out    (lt_upd),
        .eq_out    (eq_upd)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last_bit)  state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs are pure state decodes: no combinational path from
    // in_valid or out_ready.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Datapath: operand shift registers, bit counter and result accumulators
    always_ff @(posedge clk) begin
        if (rst) begin
            sa      <= '0;
            sb      <= '0;
            mode    <= CMP_UNSIGNED;
            counter <= '0;
            lt_acc  <= 1'b0;
            eq_acc  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sa      <= a;
                        sb      <= b;
                        mode    <= is_signed;
                        counter <= '0;
                        lt_acc  <= 1'b0;
                        eq_acc  <= 1'b1;
                    end
                end
                RUN: begin
                    lt_acc  <= lt_upd;
                    eq_acc  <= eq_upd;
                    sa      <= {1'b0, sa[WIDTH-1:1]};
                    sb      <= {1'b0, sb[WIDTH-1:1]};
                    counter <= counter + CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign lt = lt_acc;
    assign eq = eq_acc;

endmodule
